ibus_sram_responder: RTL and testbench

//   Slave end of the instruction bus: accepts fetch-stage ibus requests and

---
 rtl/ibus_sram_responder_pkg.sv | 30 +++
 rtl/ibus_sram_responder_mem_array.sv | 32 +++
 rtl/ibus_sram_responder.sv | 136 +++++++++++++
 tb/tb_ibus_sram_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ibus_sram_responder_pkg.sv
// Shared instruction-bus types and constants for the SRAM responder.
//   ibus_req_t       : {valid, addr[63:0]} from fetch
//   ibus_resp_t      : {addr_ok, data_ok, data[31:0]} back to fetch
//   IBUS_NOP         : instruction returned for bad fetch addresses
//   ibus_rsp_state_t : responder FSM states
package ibus_sram_responder_pkg;

  localparam int unsigned IBUS_ADDR_W = 64;
  localparam int unsigned IBUS_DATA_W = 32;

  localparam logic [IBUS_DATA_W-1:0] IBUS_NOP = 32'h0000_0013;

  typedef struct packed {
    logic                   valid;
    logic [IBUS_ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [IBUS_DATA_W-1:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ibus_rsp_state_t;

endpackage

// File: rtl/ibus_sram_responder_mem_array.sv
// Word-organised instruction storage: one asynchronous read port and one
// synchronous write port. Contents are never reset.
//   clk      : clock
//   we_i     : write strobe
//   waddr_i  : write word index
//   wdata_i  : write word
//   raddr_i  : read word index
//   rdata_o  : read word (combinational; same-cycle write not visible)
module ibus_mem_array #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibus_sram_responder.sv
// Instruction-bus slave answering fetch requests from an instruction SRAM
// after a fixed latency, with a side port for program preload.
//   clk, rst  : clock, synchronous active-high reset
//   ireq_i    : fetch request {valid, addr}
//   iresp_o   : {addr_ok, data_ok, data}; addr_ok/data_ok are same-cycle
//               responses to ireq_i
//   ld_en_i   : preload write strobe (honoured in any state, even in reset)
//   ld_idx_i  : preload word index
//   ld_data_i : preload word
//   busy_o    : request in flight
//   fault_o   : pulses with data_ok when the address was bad
module ibus_sram_responder
  import ibus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  ibus_req_t                ireq_i,
  output ibus_resp_t               iresp_o,
  input  logic                     ld_en_i,
  input  logic [$clog2(DEPTH)-1:0] ld_idx_i,
  input  logic [31:0]              ld_data_i,
  output logic                     busy_o,
  output logic                     fault_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  ibus_rsp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q, addr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bad_q, bad_d;

  logic [63:0]      off;
  logic             dec_bad;
  logic [IDX_W-1:0] dec_idx;
  logic             match;
  logic             addr_ok;
  logic             data_ok;
  logic             resp_ok;
  logic [31:0]      rdata;

  ibus_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (ld_en_i),
    .waddr_i (ld_idx_i),
    .wdata_i (ld_data_i),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  // Decode: addresses below BASE wrap to a huge offset and fail the range test
  always_comb begin
    off     = ireq_i.addr - BASE;
    dec_bad = (ireq_i.addr[1:0] != 2'b00) || (off >= (64'(DEPTH) << 2));
    dec_idx = off[IDX_W+1:2];
  end

  // Requester still presenting the latched fetch
  assign match = ireq_i.valid && (ireq_i.addr == addr_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
    end
  end

  // Next state; a dropped or changed request in WAIT/RESP cancels the fetch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ireq_i.valid) begin
          addr_ok = 1'b1;
          addr_d  = ireq_i.addr;
          idx_d   = dec_idx;
          bad_d   = dec_bad;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!match) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        data_ok = match;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response drive; held quiet while reset is asserted
  always_comb begin
    resp_ok         = data_ok & ~rst;
    iresp_o         = '0;
    iresp_o.addr_ok = addr_ok & ~rst;
    iresp_o.data_ok = resp_ok;
    if (resp_ok) begin
      iresp_o.data = bad_q ? IBUS_NOP : rdata;
    end
    fault_o = resp_ok & bad_q;
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Directed bench for ibus_sram_responder: a LATENCY=2 instance for most
// scenarios and a LATENCY=1 instance for back-to-back streaming.
module tb_ibus_sram_responder;
  import ibus_sram_responder_pkg::*;

  localparam int unsigned DEPTH = 4096;

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  ireq, ireq1;
  ibus_resp_t iresp, iresp1;
  logic       ld_en;
  logic [11:0] ld_idx;
  logic [31:0] ld_data;
  logic       busy, busy1, fault, fault1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ibus_sram_responder #(.DEPTH(DEPTH), .BASE(64'h8000_0000), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .ireq_i(ireq), .iresp_o(iresp),
    .ld_en_i(ld_en), .ld_idx_i(ld_idx), .ld_data_i(ld_data),
    .busy_o(busy), .fault_o(fault)
  );

  ibus_sram_responder #(.DEPTH(DEPTH), .BASE(64'h8000_0000), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ireq_i(ireq1), .iresp_o(iresp1),
    .ld_en_i(ld_en), .ld_idx_i(ld_idx), .ld_data_i(ld_data),
    .busy_o(busy1), .fault_o(fault1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    cyc();
    ld_en = 1'b0;
  endtask

  // Full LATENCY=2 read starting from IDLE, valid held throughout
  task automatic read2(input string tag, input logic [63:0] addr,
                       input logic [31:0] exp_data, input logic exp_fault);
    ireq.valid = 1'b1; ireq.addr = addr;
    #1;
    check({tag, ".addr_ok"}, 64'(iresp.addr_ok), 64'd1);
    check({tag, ".no_data_T"}, 64'(iresp.data_ok), 64'd0);
    cyc(); #1;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".no_data_T1"}, 64'(iresp.data_ok), 64'd0);
    cyc(); #1;
    check({tag, ".data_ok"}, 64'(iresp.data_ok), 64'd1);
    check({tag, ".data"}, 64'(iresp.data), 64'(exp_data));
    check({tag, ".fault"}, 64'(fault), 64'(exp_fault));
    check({tag, ".no_aok"}, 64'(iresp.addr_ok), 64'd0);
    ireq.valid = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    ireq = '0; ireq1 = '0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;

    // Preload while reset is held (both instances share the load port)
    preload(12'd0,  32'h0010_0093);
    preload(12'd1,  32'h1234_5678);
    preload(12'd2,  32'hAAAA_0002);
    preload(12'd3,  32'h3333_0003);
    preload(12'd64, 32'h0400_0100);
    #1;
    check("rst.iresp", 64'(iresp), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.fault", 64'(fault), 64'd0);
    rst = 1'b0;
    cyc();

    // Basic read with two-cycle latency
    read2("rd0", 64'h8000_0000, 32'h0010_0093, 1'b0);

    // Bad addresses: misaligned, one past the end, below BASE
    read2("mis", 64'h8000_0002, 32'h0000_0013, 1'b1);
    read2("end", 64'h8000_4000, 32'h0000_0013, 1'b1);
    read2("low", 64'h7FFF_FFFC, 32'h0000_0013, 1'b1);
    read2("last_ok", 64'h8000_0008, 32'hAAAA_0002, 1'b0);

    // Redirect during WAIT cancels the old fetch and restarts
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0008;
    #1; check("redir.aok0", 64'(iresp.addr_ok), 64'd1);
    cyc();
    ireq.addr = 64'h8000_0100;
    #1; check("redir.no_dok1", 64'(iresp.data_ok), 64'd0);
    check("redir.no_aok1", 64'(iresp.addr_ok), 64'd0);
    cyc(); #1;
    check("redir.idle", 64'(busy), 64'd0);
    check("redir.aok2", 64'(iresp.addr_ok), 64'd1);
    check("redir.no_dok2", 64'(iresp.data_ok), 64'd0);
    cyc(); #1;
    check("redir.no_dok3", 64'(iresp.data_ok), 64'd0);
    cyc(); #1;
    check("redir.dok4", 64'(iresp.data_ok), 64'd1);
    check("redir.data4", 64'(iresp.data), 64'h0400_0100);
    check("redir.fault4", 64'(fault), 64'd0);
    ireq.valid = 1'b0;
    cyc();

    // Reset while in WAIT drops the request
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0000;
    cyc();
    rst = 1'b1;
    #1; check("rstw.busy_pre", 64'(busy), 64'd1);
    cyc(); #1;
    check("rstw.iresp", 64'(iresp), 64'd0);
    check("rstw.busy", 64'(busy), 64'd0);
    check("rstw.fault", 64'(fault), 64'd0);
    rst = 1'b0; ireq.valid = 1'b0;
    cyc(); #1;
    check("rstw.no_dok", 64'(iresp.data_ok), 64'd0);
    cyc();

    // Preload collision with RESP returns old data, then new data
    ireq.valid = 1'b1; ireq.addr = 64'h8000_000C;
    cyc(); cyc();
    ld_en = 1'b1; ld_idx = 12'd3; ld_data = 32'h5555_0003;
    #1;
    check("coll.dok", 64'(iresp.data_ok), 64'd1);
    check("coll.old", 64'(iresp.data), 64'h3333_0003);
    ireq.valid = 1'b0;
    cyc();
    ld_en = 1'b0;
    read2("coll.new", 64'h8000_000C, 32'h5555_0003, 1'b0);

    // LATENCY=1 instance: held valid streams with one bubble
    ireq1.valid = 1'b1; ireq1.addr = 64'h8000_0004;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("b2b.aok%0d", k), 64'(iresp1.addr_ok), 64'((k % 2) == 0));
      check($sformatf("b2b.dok%0d", k), 64'(iresp1.data_ok), 64'((k % 2) == 1));
      check($sformatf("b2b.data%0d", k), 64'(iresp1.data),
            ((k % 2) == 1) ? 64'h1234_5678 : 64'd0);
      check($sformatf("b2b.ovl%0d", k), 64'(iresp1.addr_ok & iresp1.data_ok), 64'd0);
      cyc();
    end
    ireq1.valid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
